// File: rtl/bch_stream_encoder.sv
// Systematic serial BCH/CRC encoder: passes K message bits through, then
// appends R=N-K Galois LFSR parity bits (LSB first) and flags frame end.
// Ports: clk, rst (async, active-high), clear (sync abort),
//   s_valid/s_ready/s_data (message in), m_valid/m_ready/m_data (codeword out),
//   m_last (N-th bit), frame_done (pulse after last transfer),
//   parity_out[R-1:0] (only with BCH_ENC_PARALLEL_OUT_EN defined).
module bch_stream_encoder #(
   parameter int N = 64,
   parameter int K = 40,
   parameter logic [N-K-1:0] TAP_MASK = 24'h884110
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic s_valid,
   output logic s_ready,
   input  logic s_data,
   output logic m_valid,
   input  logic m_ready,
   output logic m_data,
   output logic m_last,
   output logic frame_done
`ifdef BCH_ENC_PARALLEL_OUT_EN
   ,
   output logic [N-K-1:0] parity_out
`endif
);

   localparam int R  = N - K;
   localparam int CW = $clog2(N);

   typedef enum logic {
      MSG = 1'b0,
      PAR = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [R-1:0]   lfsr_q, lfsr_d, lfsr_msg;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           done_q, done_d;
   logic           xfer, fb, msg_end, par_end;

   assign msg_end = (cnt_q == CW'(K - 1));
   assign par_end = (cnt_q == CW'(N - 1));

   always_comb begin
      fb       = s_data ^ lfsr_q[0];
      lfsr_msg = {fb, lfsr_q[R-1:1] ^ (TAP_MASK[R-2:0] & {(R-1){fb}})};

      s_ready  = 1'b0;
      m_valid  = 1'b0;
      m_data   = 1'b0;
      m_last   = 1'b0;
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;

      unique case (state_q)
         MSG: begin
            s_ready = m_ready & ~clear;
            m_valid = s_valid & ~clear;
            m_data  = s_data;
         end
         PAR: begin
            m_valid = ~clear;
            m_data  = lfsr_q[0];
            m_last  = par_end;
         end
      endcase

      // m_valid already carries ~clear, so clear blocks the transfer
      xfer = m_valid & m_ready;

      if (clear) begin
         state_d = MSG;
         lfsr_d  = '0;
         cnt_d   = '0;
      end else if (xfer) begin
         if (state_q == MSG) begin
            lfsr_d = lfsr_msg;
            cnt_d  = cnt_q + CW'(1);
            if (msg_end) state_d = PAR;
         end else if (par_end) begin
            state_d = MSG;
            lfsr_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
         end else begin
            lfsr_d = {1'b0, lfsr_q[R-1:1]};
            cnt_d  = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MSG;
         lfsr_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign frame_done = done_q;

`ifdef BCH_ENC_PARALLEL_OUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity_out <= '0;
      else if (clear)
         parity_out <= '0;
      else if (xfer && state_q == MSG && msg_end)
         parity_out <= lfsr_msg;
   end
`endif

endmodule

// File: doc/bch_stream_encoder.md
# bch_stream_encoder

Parametrised systematic serial BCH/CRC encoder for the 64/40 link path, built as the next generation of the fixed 24-bit remainder register. It accepts K message bits on a valid/ready bit stream and forwards them unchanged. It then appends the R = N−K parity bits computed by a right-shifting Galois LFSR with a configurable tap mask, and marks frame boundaries. It sits between the framer and the serialiser.

## Interface
- N, 64, codeword length in bits; must be greater than K.
- K, 40, message length in bits; R = N−K is a derived localparam.
- TAP_MASK, 24'h884110, R-bit feedback mask; bit R−1 must be 1; the default is the 64/40 generator.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous frame abort.
- s_valid  in  1  message bit valid.
- s_ready  out  1  encoder accepts the message bit.
- s_data  in  1  message bit.
- m_valid  out  1  codeword bit valid.
- m_ready  in  1  downstream accepts the codeword bit.
- m_data  out  1  codeword bit.
- m_last  out  1  high on the final (N-th) codeword bit.
- frame_done  out  1  one-cycle pulse after the last parity bit transfers.
- parity_out  out  R  parity snapshot; present only with the macro (see Configuration).

## Operation
- State: `lfsr[R-1:0]`, `cnt` ($clog2(N) bits, 0..N−1), FSM {MSG, PAR}.
- **MSG state:**
  - `s_ready = m_ready & ~clear`.
  - `m_valid = s_valid & ~clear`.
  - `m_data = s_data`.
- A transfer (`s_valid & m_ready & ~clear`) applies the LFSR update:
  - `fb = s_data ^ lfsr[0]`.
  - `lfsr_next[R-1] = fb`.
  - `lfsr_next[j] = lfsr[j+1] ^ (fb & TAP_MASK[j])` for j < R−1.
  - `cnt` increments.
- On the K-th message transfer (`cnt == K−1`), the FSM goes to PAR.
- **PAR state:**
  - `s_ready = 0`.
  - `m_valid = ~clear`.
  - `m_data = lfsr[0]`.
- Each PAR transfer shifts the LFSR right with 0 in at bit R−1 and increments `cnt`. Parity is therefore emitted LSB (`lfsr[0]`) first.
- `m_last = (state == PAR) & (cnt == N−1)`.
- On the last transfer:
  - `cnt` returns to 0, `lfsr` returns to 0, and the FSM returns to MSG.
  - `frame_done` is registered high for exactly the next cycle.
- `clear`:
  - Forces `cnt`, `lfsr` and the FSM to 0/MSG on the next edge.
  - Suppresses the handshake in the same cycle, so no transfer occurs.
  - Does not assert `frame_done`.
- `m_valid` stalled with `m_ready` low: all state holds. In PAR, `m_data` stays stable.

## Timing
- Message path latency is 0 cycles (combinational pass-through). The parity bit is available in the cycle immediately after the K-th message transfer.
- At full throughput, one frame takes N cycles, with no gap between frames. The first message bit of the next frame can transfer in the cycle after `m_last`.
- Reset values:
  - `lfsr = 0`, `cnt = 0`, state = MSG.
  - `frame_done = 0`, `m_last = 0`, `parity_out = 0`.
  - `s_ready`/`m_valid` follow their combinational equations in MSG.
- `rst` asserted mid-frame discards the frame immediately. There is no partial-parity output.
- `clear` and the last transfer in the same cycle: `clear` wins, and there is no `frame_done`.

## Configuration
- `BCH_ENC_PARALLEL_OUT_EN` defined:
  - Adds the `parity_out[R-1:0]` port and register.
  - The register loads `lfsr_next` on the K-th message transfer and holds until the next such load, `rst` or `clear` (both zero it).
- Without the macro:
  - The `parity_out` port and register do not exist.
  - Serial behaviour is unchanged.

## Test plan
- All-zero 40-bit message, `m_ready` tied 1: 40 zero bits, then 24 zero parity bits. `m_last` is high at cycle 63, and `frame_done` pulses at cycle 64.
- Message of 39 zeros then a 1:
  - Parity stream (LSB first) equals 24'h884110: bits 4, 8, 14, 19 and 23 are 1, the others 0.
  - `parity_out` = 24'h884110 with the macro defined.
- Same message with `m_ready` toggling 1,0,0,1 throughout: the codeword is bit-identical to the previous case. `m_data` is stable during stalls. Completion takes ≥64 transfers.
- Assert `clear` at parity bit 10, then send the all-zero frame: no `frame_done` for the aborted frame, and the next frame's parity is all zero.
- Two back-to-back random frames: parity matches the software model (same LFSR equation). The second frame starts the cycle after `m_last`.
- Assert `rst` during MSG at `cnt` = 20: all registers are 0 within the same cycle, and a subsequent frame encodes correctly.
